// File: rtl/lock_fsm_if.sv
// Key-front-end to lock_fsm connection: trigger/code inputs and lock indications.
// The master modport is the front end; the slave modport is lock_fsm itself.
interface lock_fsm_if;
   logic       enter_trig;
   logic       init_trig;
   logic [3:0] ctrl;
   logic       unlock;
   logic       err;
   logic       alarm;
   logic [1:0] fail_cnt;
   logic [2:0] state_o;
   logic       pwd_upd;

   modport master (
      output enter_trig, init_trig, ctrl,
      input  unlock, err, alarm, fail_cnt, state_o, pwd_upd
   );

   modport slave (
      input  enter_trig, init_trig, ctrl,
      output unlock, err, alarm, fail_cnt, state_o, pwd_upd
   );
endinterface

// File: rtl/lock_fsm.sv
// Combination-lock sequencer: code check, timed open/error/alarm states, fail counting.
// Define LOCK_PWD_SET_EN to allow rewriting the password with init_trig while open.
module lock_fsm #(
   parameter logic [3:0]  PASSWORD     = 4'h9,
   parameter int unsigned MAX_FAIL     = 3,
   parameter logic [31:0] OPEN_CYCLES  = 32'd270_000_000,
   parameter logic [31:0] ERR_CYCLES   = 32'd27_000_000,
   parameter logic [31:0] ALARM_CYCLES = 32'd810_000_000
) (
   input logic        clk,
   input logic        rst,
   lock_fsm_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_OPEN  = 3'd2,
      S_ERR   = 3'd3,
      S_ALARM = 3'd4
   } state_t;

   localparam logic [2:0] FAIL_TRIP = MAX_FAIL[2:0];
   localparam logic [1:0] FAIL_SAT  = MAX_FAIL[1:0];

   state_t      state_q, state_d;
   logic [3:0]  code_q, code_d;
   logic [31:0] timer_q, timer_d;
   logic [1:0]  fail_q, fail_d;
   logic        unlock_q, unlock_d;
   logic        err_q, err_d;
   logic        alarm_q, alarm_d;
   logic [3:0]  pwd_cur;

`ifdef LOCK_PWD_SET_EN
   logic [3:0]  pwd_q, pwd_d;
   logic        pwd_upd_q, pwd_upd_d;

   assign pwd_cur     = pwd_q;
   assign bus.pwd_upd = pwd_upd_q;
`else
   logic        unused_init_trig;

   assign unused_init_trig = bus.init_trig;
   assign pwd_cur          = PASSWORD;
   assign bus.pwd_upd      = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      timer_d = timer_q;
      fail_d  = fail_q;
`ifdef LOCK_PWD_SET_EN
      pwd_d     = pwd_q;
      pwd_upd_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.enter_trig) begin
               code_d  = bus.ctrl;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (code_q == pwd_cur) begin
               fail_d  = 2'd0;
               state_d = S_OPEN;
               timer_d = OPEN_CYCLES - 32'd1;
            end else if (({1'b0, fail_q} + 3'd1) == FAIL_TRIP) begin
               fail_d  = FAIL_SAT;
               state_d = S_ALARM;
               timer_d = ALARM_CYCLES - 32'd1;
            end else begin
               fail_d  = fail_q + 2'd1;
               state_d = S_ERR;
               timer_d = ERR_CYCLES - 32'd1;
            end
         end
         S_OPEN: begin
            // Relock beats both a password write and timer expiry.
            if (bus.enter_trig) begin
               state_d = S_IDLE;
`ifdef LOCK_PWD_SET_EN
            end else if (bus.init_trig) begin
               pwd_d     = bus.ctrl;
               pwd_upd_d = 1'b1;
               timer_d   = OPEN_CYCLES - 32'd1;
`endif
            end else if (timer_q == 32'd0) begin
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         S_ERR: begin
            if (timer_q == 32'd0) state_d = S_IDLE;
            else                  timer_d = timer_q - 32'd1;
         end
         S_ALARM: begin
            if (timer_q == 32'd0) begin
               state_d = S_IDLE;
               fail_d  = 2'd0;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Indications are registered copies of the next state.
      unlock_d = (state_d == S_OPEN);
      err_d    = (state_d == S_ERR);
      alarm_d  = (state_d == S_ALARM);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         code_q    <= 4'd0;
         timer_q   <= 32'd0;
         fail_q    <= 2'd0;
         unlock_q  <= 1'b0;
         err_q     <= 1'b0;
         alarm_q   <= 1'b0;
`ifdef LOCK_PWD_SET_EN
         pwd_q     <= PASSWORD;
         pwd_upd_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         timer_q   <= timer_d;
         fail_q    <= fail_d;
         unlock_q  <= unlock_d;
         err_q     <= err_d;
         alarm_q   <= alarm_d;
`ifdef LOCK_PWD_SET_EN
         pwd_q     <= pwd_d;
         pwd_upd_q <= pwd_upd_d;
`endif
      end
   end

   assign bus.unlock   = unlock_q;
   assign bus.err      = err_q;
   assign bus.alarm    = alarm_q;
   assign bus.fail_cnt = fail_q;
   assign bus.state_o  = state_q;

endmodule
